// File: rtl/rfbank_if.sv
// Bundles the read, write and reserve ports of the register file.
// Pure wiring: no storage, so no latency of its own.
// No backpressure; the only flow indication is ready.
interface rfbank_if #(
    parameter int NREAD = 2,
    parameter int WRFI  = 5,
    parameter int WDATA = 32
);
    logic                   ready;
    logic [NREAD*WRFI-1:0]  rd_idx;
    logic [NREAD*WDATA-1:0] rd_data;
    logic [NREAD-1:0]       rd_pend;
    logic                   wr_en;
    logic [WRFI-1:0]        wr_idx;
    logic [WDATA-1:0]       wr_data;
    logic                   rsv_en;
    logic [WRFI-1:0]        rsv_idx;

    // Core side
    modport master (
        input  ready, rd_data, rd_pend,
        output rd_idx, wr_en, wr_idx, wr_data, rsv_en, rsv_idx
    );

    // Register-file side
    modport slave (
        output ready, rd_data, rd_pend,
        input  rd_idx, wr_en, wr_idx, wr_data, rsv_en, rsv_idx
    );
endinterface

// File: rtl/rfbank.sv
// Multi-port register file with x0 hardwired to zero, pending scoreboard and post-reset zero sweep.
// Reads are combinational (0 cycles); writes and reservations take effect after 1 edge; sweep is NUMREGS-1 edges.
// No backpressure: write/reserve strobes before ready are dropped. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module rfbank #(
    parameter int NUMREGS = 32,
    parameter int NREAD   = 2,
    parameter int WDATA   = 32
) (
    input  logic     clk,
    input  logic     rst,
    rfbank_if.slave  bus
);
    localparam int WRFI = $clog2(NUMREGS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [WRFI-1:0]     cnt_q, cnt_d;
    logic [NUMREGS-1:0]  pend_q, pend_d;
    // Entry 0 exists only to keep indexing simple; it is never read out.
    logic [WDATA-1:0]    regs_q [NUMREGS];
    logic [WDATA-1:0]    regs_d [NUMREGS];

    logic [NREAD*WDATA-1:0] rd_data;
    logic [NREAD-1:0]       rd_pend;
    logic [WRFI-1:0]        idx;

    // Next state: sweep zeros while clearing, otherwise apply writes then reservations (reservation wins).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        regs_d  = regs_q;
        if (state_q == CLEAR) begin
            for (int r = 1; r < NUMREGS; r++) begin
                if (cnt_q == WRFI'(r)) begin
                    regs_d[r] = '0;
                end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == WRFI'(NUMREGS - 1)) begin
                state_d = RUN;
            end
        end else begin
            // Index 0 and out-of-range indices never match, so they fall away here.
            for (int r = 1; r < NUMREGS; r++) begin
                if (bus.wr_en && bus.wr_idx == WRFI'(r)) begin
                    regs_d[r] = bus.wr_data;
                    pend_d[r] = 1'b0;
                end
            end
            for (int r = 1; r < NUMREGS; r++) begin
                if (bus.rsv_en && bus.rsv_idx == WRFI'(r)) begin
                    pend_d[r] = 1'b1;
                end
            end
        end
    end

    // Control and scoreboard registers; reset restarts the sweep at index 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= WRFI'(1);
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Register array; reset does not touch contents, the sweep does.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= regs_d;
        end
    end

    // Read ports: zero while clearing or for x0/out-of-range, optional forward of the same-cycle write.
    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        idx     = '0;
        for (int p = 0; p < NREAD; p++) begin
            idx = bus.rd_idx[p*WRFI +: WRFI];
            if (state_q == RUN) begin
                for (int r = 1; r < NUMREGS; r++) begin
                    if (idx == WRFI'(r)) begin
                        rd_data[p*WDATA +: WDATA] = regs_q[r];
                        rd_pend[p]                = pend_q[r];
`ifdef REGFILE_BYPASS_EN
                        if (bus.wr_en && bus.wr_idx == idx) begin
                            rd_data[p*WDATA +: WDATA] = bus.wr_data;
                            rd_pend[p]                = bus.rsv_en && (bus.rsv_idx == idx);
                        end
`endif
                    end
                end
            end
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.rd_pend = rd_pend;
    assign bus.ready   = (state_q == RUN);

endmodule

// File: doc/rfbank.md
# rfbank

Multi-port register file for the microcoded core family, replacing the single-port, combinationally read file built into the core wrapper. It provides `NREAD` independent read ports, one write port, x0 hardwired to zero, and a per-register pending scoreboard for multi-cycle writebacks. A post-reset clear sweep guarantees every register reads zero before the core starts. It sits between the core datapath and the register array, one instance per core.

## Interface
- `NUMREGS`, 32: number of architectural registers, at least 2. Any value is legal; a power of two is not required.
- `NREAD`, 2: number of read ports, at least 1.
- `WDATA`, 32: register width in bits.
- `WRFI` (localparam): `$clog2(NUMREGS)`, the index width.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ready`  out  1: high once the clear sweep has finished.
- `rd_idx`  in  `NREAD*WRFI`: packed read indices. Port p uses bits `[p*WRFI +: WRFI]`.
- `rd_data`  out  `NREAD*WDATA`: packed read data, combinational.
- `rd_pend`  out  `NREAD`: pending bit of each read index, combinational.
- `wr_en`  in  1: write strobe.
- `wr_idx`  in  `WRFI`: write index.
- `wr_data`  in  `WDATA`: write data.
- `rsv_en`  in  1: reserve strobe; sets the pending bit of `rsv_idx`.
- `rsv_idx`  in  `WRFI`: index to reserve.

## Operation
- **States:**
  - `CLEAR`: sweeping zeros through the array.
  - `RUN`: normal operation.
- **Reset:** `rst` high at an edge sets state to `CLEAR`, the sweep counter to 1 and all pending bits to 0. It does not write the array.
- **`CLEAR` state:**
  - Each edge writes `regfile[cnt] <= 0` and increments `cnt`.
  - When `cnt == NUMREGS-1`, that write happens and the state moves to `RUN`.
  - `wr_en` and `rsv_en` are ignored.
  - `ready = 0`; all `rd_data` are 0 and all `rd_pend` are 0.
- **Writes in `RUN`:** with `wr_en` and `0 < wr_idx < NUMREGS`, the array is written and `pending[wr_idx]` is cleared. The clear happens whether or not the bit was set.
- **Reservations in `RUN`:** with `rsv_en` and `0 < rsv_idx < NUMREGS`, `pending[rsv_idx]` is set.
- **Write and reserve to the same index in one cycle:** the reservation wins, so the pending bit ends at 1. The data is still written.
- **Index 0:** reads return 0 with `rd_pend = 0`; writes and reservations to it are no-ops.
- **Out-of-range index** (`>= NUMREGS`): reads return 0 with `rd_pend = 0`; writes and reservations are dropped.
- **Read ports:** independent of each other. Several ports may use the same index.
- **Reset during `CLEAR`:** the sweep restarts from index 1.
- **Reset during `RUN`:** `ready` drops at that edge and the sweep reruns.

## Timing
- **Reset values:**
  - `ready = 0`.
  - `rd_data = 0`.
  - `rd_pend = 0`.
  - Pending array all 0.
  - Array contents are undefined until the sweep completes.
- **Sweep length:** after the last edge with `rst` high, `ready` rises after exactly `NUMREGS-1` edges. For `NUMREGS = 32` that is the 31st edge.
- **Read latency:** 0 cycles. `rd_data` and `rd_pend` are combinational from `rd_idx` and registered state; the bypass path below adds a combinational dependency on the write port.
- **Write latency:** 1 edge. Without bypass, a read of the written index returns the new value from the cycle after `wr_en`.
- **Reserve latency:** 1 edge. `rd_pend` goes high from the cycle after `rsv_en`.
- **Handshake:** there is none beyond `ready`. The core must not issue `wr_en` or `rsv_en` before `ready`; any it does issue are discarded.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** in `RUN`, a read port whose index matches an active, legal, nonzero `wr_idx` in the same cycle returns `wr_data`. Its `rd_pend` is also forced to 0, unless the same-cycle `rsv_en` targets that index, in which case `rd_pend` is 1.
- **`REGFILE_BYPASS_EN` undefined:** reads return the registered array value and the registered pending bit. There is no combinational path from the write or reserve ports to the read outputs.

## Test plan
- **Reset sweep:** `NUMREGS = 32`, pulse `rst` for 1 cycle -> `ready` is 0 for 30 cycles and 1 on the 31st edge; every index reads 0 afterwards.
- **Write/read and x0:**
  - Write `0xDEADBEEF` to r5, then read r5 on both ports -> `0xDEADBEEF` the next cycle.
  - Write to r0 -> reading r0 still returns 0.
- **Scoreboard:**
  - Reserve r7 -> `rd_pend = 1` the next cycle.
  - Write r7 -> `rd_pend = 0` the next cycle.
  - Reserve and write r7 in the same cycle -> `rd_pend` stays 1 and the data is updated.
- **Bypass:** r3 holds `0x11`; write `0x22` to r3 while reading r3 in the same cycle.
  - With `REGFILE_BYPASS_EN` -> reads `0x22`.
  - Without it -> reads `0x11`, then `0x22` the next cycle.
- **Reset mid-sweep and out of range:**
  - Assert `rst` 10 cycles into the sweep -> `ready` rises 31 edges after the second reset.
  - `NUMREGS = 24`: read and write index 30 -> reads 0 and no register changes.
- **Pre-ready traffic:** issue `wr_en` to r4 with `0x55` and `rsv_en` to r4 during `CLEAR` -> after `ready`, r4 reads 0 with `rd_pend = 0`.
